// File: rtl/cla_sub_pipe.sv
// rtl/cla_sub_pipe.sv - 2-stage 8-bit carry-lookahead subtractor; CLA_SUB_SATURATE_EN clamps diff to 0x00 on borrow
module cla_sub_pipe (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       borrow_in,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] diff,
   output logic       borrow_out,
   output logic       overflow,
   output logic       zero
);

   // 4-bit lookahead group: returns {group carry-out, c3, c2, c1, c0}
   function automatic logic [4:0] cla4(input logic [3:0] p, input logic [3:0] g, input logic c0);
      logic [4:0] c;
      logic       gg;
      logic       pp;
      gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      pp   = &p;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c[4] = gg | (pp & c0);
      return c;
   endfunction

   // stage valids and handshake
   logic       r_s1_v;
   logic       r_s2_v;
   logic       w_s2_adv;
   logic       w_s1_adv;

   // stage-1 data
   logic [3:0] r_s1_sum_lo;
   logic       r_s1_c4;
   logic [3:0] r_s1_p_hi;
   logic [3:0] r_s1_g_hi;
   logic       r_s1_a7;
   logic       r_s1_b7;

   // stage-2 (output) data
   logic [7:0] r_diff;
   logic       r_borrow;
   logic       r_ovf;
   logic       r_zero;

   // subtraction as a + ~b + ~borrow_in
   logic [7:0] w_nb;
   logic [7:0] w_p;
   logic [7:0] w_g;
   logic [4:0] w_c_lo;
   logic [3:0] w_sum_lo;

   logic [4:0] w_c_hi;
   logic [3:0] w_sum_hi;
   logic [7:0] w_diff_raw;
   logic [7:0] w_diff_fin;
   logic       w_borrow;
   logic       w_ovf;

   assign w_s2_adv = !r_s2_v | out_ready;
   assign w_s1_adv = !r_s1_v | w_s2_adv;
   // held low through reset so nothing is taken while the pipe is being flushed
   assign in_ready = w_s1_adv & !rst;

   assign w_nb     = ~b;
   assign w_p      = a ^ w_nb;
   assign w_g      = a & w_nb;
   assign w_c_lo   = cla4(w_p[3:0], w_g[3:0], ~borrow_in);
   assign w_sum_lo = w_p[3:0] ^ w_c_lo[3:0];

   assign w_c_hi     = cla4(r_s1_p_hi, r_s1_g_hi, r_s1_c4);
   assign w_sum_hi   = r_s1_p_hi ^ w_c_hi[3:0];
   assign w_diff_raw = {w_sum_hi, r_s1_sum_lo};
   assign w_borrow   = ~w_c_hi[4];
   assign w_ovf      = (r_s1_a7 ^ r_s1_b7) & (w_diff_raw[7] ^ r_s1_a7);

`ifdef CLA_SUB_SATURATE_EN
   assign w_diff_fin = w_borrow ? 8'h00 : w_diff_raw;
`else
   assign w_diff_fin = w_diff_raw;
`endif

   // pipeline occupancy: each stage refills when it advances
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_v <= 1'b0;
         r_s2_v <= 1'b0;
      end else begin
         if (w_s1_adv) r_s1_v <= in_valid;
         if (w_s2_adv) r_s2_v <= r_s1_v;
      end
   end

   // stage 1 captures low-nibble result and high-nibble propagate/generate
   always_ff @(posedge clk) begin
      if (w_s1_adv && in_valid) begin
         r_s1_sum_lo <= w_sum_lo;
         r_s1_c4     <= w_c_lo[4];
         r_s1_p_hi   <= w_p[7:4];
         r_s1_g_hi   <= w_g[7:4];
         r_s1_a7     <= a[7];
         r_s1_b7     <= b[7];
      end
   end

   // stage 2 finishes the high nibble and registers the result flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_diff   <= 8'h00;
         r_borrow <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
      end else if (w_s2_adv && r_s1_v) begin
         r_diff   <= w_diff_fin;
         r_borrow <= w_borrow;
         r_ovf    <= w_ovf;
         r_zero   <= (w_diff_fin == 8'h00);
      end
   end

   assign out_valid  = r_s2_v;
   assign diff       = r_diff;
   assign borrow_out = r_borrow;
   assign overflow   = r_ovf;
   assign zero       = r_zero;

endmodule
